vram_fast_ctrl: RTL and testbench
=================================

# vram_fast_ctrl

Synchronous initiator for the fast VRAM pair (two 2048×8 async SRAMs, L and U halves, shared address and strobes, 30 ns access). Sequences host (68k register port) reads and writes and video-fetch reads onto the SRAM pins. Maintains the host auto-increment address pointer with a programmable modulo. Sits inside the LSPC, between its register block and fetch engine on one side and the fast VRAM chips on the other.

## Interface
Parameters:
- ADDR_W, 11, SRAM address width
- DATA_W, 16, combined L+U data width

Ports:
- CLK_24M  in  1  system clock; single clock domain
- RESET  in  1  synchronous, active-high reset
- HOST_REQ  in  1  host access request; held until HOST_ACK
- HOST_WR  in  1  1 = write, 0 = read; stable while HOST_REQ
- HOST_WDATA  in  16  write data; stable while HOST_REQ
- HOST_ACK  out  1  one-cycle completion pulse
- HOST_RDATA  out  16  last host read data; held until next host read
- PTR_LD  in  1  load host pointer from PTR_IN
- PTR_IN  in  11  pointer load value
- MOD_LD  in  1  load modulo from MOD_IN
- MOD_IN  in  11  modulo (increment) value
- PTR  out  11  current host pointer
- FETCH_REQ  in  1  video fetch request; held until FETCH_VALID
- FETCH_ADDR  in  11  fetch address; stable while FETCH_REQ
- FETCH_VALID  out  1  one-cycle pulse; FETCH_DATA valid
- FETCH_DATA  out  16  last fetched word; held
- ADDR  out  11  SRAM address
- DATA  inout  16  SRAM data; [7:0] to L, [15:8] to U
- nCE  out  1  SRAM chip enable, active low
- nOE  out  1  SRAM output enable, active low
- nWE  out  1  SRAM write enable, active low

## Operation
- All SRAM-side outputs are registered; DATA is driven only in write states, else 16'bz.
- States: IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: FETCH_REQ takes priority over HOST_REQ. Fetch → RD_SETUP with ADDR = FETCH_ADDR. Host read → RD_SETUP with ADDR = PTR. Host write → WR_SETUP with ADDR = PTR. Owner (fetch or host) is latched at this transition.
- RD_SETUP: nCE=0, nOE=0 → RD_SAMPLE.
- RD_SAMPLE: strobes still low. At the end of the cycle: latch DATA into FETCH_DATA or HOST_RDATA, drive nCE/nOE high, pulse the matching VALID or ACK, → IDLE.
- WR_SETUP: nCE=0, nWE=1, DATA driven → WR_PULSE.
- WR_PULSE: nWE=0 → WR_HOLD.
- WR_HOLD: nWE=1, nCE=0, DATA still driven. At the end of the cycle: nCE high, DATA released, HOST_ACK pulse, → IDLE.
- Pointer update: on every HOST_ACK, PTR ← (PTR + MOD) mod 2048 (11-bit wrap, carry discarded).
- PTR_LD in the same cycle as HOST_ACK: the load wins and no increment is applied. MOD_LD takes effect on the next increment.
- PTR_LD/MOD_LD during a host access in flight: ADDR already latched is unaffected.
- A request arriving mid-access waits. After any access, fetch is re-evaluated first, so host can be starved only while FETCH_REQ stays continuously asserted.
- Reset values: nCE=nOE=nWE=1, DATA=z, ADDR=0, HOST_ACK=0, FETCH_VALID=0, HOST_RDATA=0, FETCH_DATA=0, PTR=0, MOD=1, state IDLE.
- RESET mid-access aborts immediately. Strobes go high and DATA goes z at that edge. No ACK/VALID is issued. A partial write may corrupt that one SRAM word.

## Timing
- Request sampled at edge k in IDLE.
- Read: strobes low from k+1. Data latched at k+2. ACK/VALID high in cycle k+2..k+3. Back-to-back read throughput is one per 3 cycles (IDLE inclusive).
- Write: nWE low for exactly one cycle (k+2..k+3). Address and data stable from k+1 to k+4 (one cycle of setup and one of hold around nWE). ACK in cycle k+3..k+4.
- Read sample occurs ≥2 clock periods (~83 ns) after ADDR change, which exceeds the SRAM's 30 ns access time.
- nOE and nWE are never low simultaneously.

## Structure
- Package vram_fast_pkg: state enum, ADDR_W/DATA_W constants, reset values (MOD_RESET = 11'd1).
- Sub-module vram_fast_ptr: pointer/modulo registers, load/increment priority, PTR output.
- Bench uses the existing fast VRAM behavioural models (L and U) on DATA[7:0]/DATA[15:8].

## Test plan
- Reset, then MOD_LD=3, PTR_LD=0x7FE, two host writes 0xA5A5, 0x5A5A → SRAM[0x7FE]=0xA5A5, SRAM[0x001]=0x5A5A (wrap), PTR=0x004.
- Host read at PTR=0x010 with SRAM[0x010]=0x1234 → HOST_RDATA=0x1234, ACK exactly 2 cycles after request sampled, PTR=0x011 (MOD=1).
- FETCH_REQ and HOST_REQ asserted in the same cycle → fetch served first (FETCH_VALID at k+2), host ACK follows no earlier than k+5.
- PTR_LD=0x100 in the same cycle as HOST_ACK → PTR=0x100, not 0x100+MOD.
- RESET asserted during WR_PULSE → next edge nCE=nWE=1, DATA=z, no ACK, PTR=0.
- Continuous protocol checker: nOE&nWE never both low; DATA driven only when nWE path active; ACK/VALID are single-cycle pulses.

Source files
------------

// File: rtl/vram_fast_pkg.sv
// Shared types and constants for the fast VRAM controller: FSM states,
// access owner and the reset values of the host pointer logic.
package vram_fast_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] PTR_RESET = 11'd0;
  localparam logic [ADDR_W-1:0] MOD_RESET = 11'd1;

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_SAMPLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_e;

  typedef enum logic {
    OWN_HOST,
    OWN_FETCH
  } owner_e;

endpackage

// File: rtl/vram_fast_ctrl_if.sv
// Host register-port and video-fetch side of the fast VRAM controller.
// The master is the LSPC register block / fetch engine, the slave the controller.
interface vram_fast_ctrl_if #(
  parameter int ADDR_W = vram_fast_pkg::ADDR_W,
  parameter int DATA_W = vram_fast_pkg::DATA_W
);

  logic              HOST_REQ;
  logic              HOST_WR;
  logic [DATA_W-1:0] HOST_WDATA;
  logic              HOST_ACK;
  logic [DATA_W-1:0] HOST_RDATA;
  logic              PTR_LD;
  logic [ADDR_W-1:0] PTR_IN;
  logic              MOD_LD;
  logic [ADDR_W-1:0] MOD_IN;
  logic [ADDR_W-1:0] PTR;
  logic              FETCH_REQ;
  logic [ADDR_W-1:0] FETCH_ADDR;
  logic              FETCH_VALID;
  logic [DATA_W-1:0] FETCH_DATA;

  modport master (
    output HOST_REQ, HOST_WR, HOST_WDATA, PTR_LD, PTR_IN, MOD_LD, MOD_IN,
           FETCH_REQ, FETCH_ADDR,
    input  HOST_ACK, HOST_RDATA, PTR, FETCH_VALID, FETCH_DATA
  );

  modport slave (
    input  HOST_REQ, HOST_WR, HOST_WDATA, PTR_LD, PTR_IN, MOD_LD, MOD_IN,
           FETCH_REQ, FETCH_ADDR,
    output HOST_ACK, HOST_RDATA, PTR, FETCH_VALID, FETCH_DATA
  );

endinterface

// File: rtl/vram_fast_ptr.sv
// Host auto-increment pointer with programmable modulo. A load beats the
// increment; a modulo load only affects increments after it has landed.
module vram_fast_ptr #(
  parameter int ADDR_W = vram_fast_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ptr_ld_i,
  input  logic [ADDR_W-1:0] ptr_in_i,
  input  logic              mod_ld_i,
  input  logic [ADDR_W-1:0] mod_in_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic [ADDR_W-1:0] ptr_nxt_o
);
  import vram_fast_pkg::*;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] mod_q, mod_d;

  // The add simply drops its carry, giving the 11-bit wrap for free.
  always_comb begin
    ptr_d = ptr_q;
    mod_d = mod_q;
    if (ptr_ld_i) begin
      ptr_d = ptr_in_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + mod_q;
    end
    if (mod_ld_i) begin
      mod_d = mod_in_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= ADDR_W'(PTR_RESET);
      mod_q <= ADDR_W'(MOD_RESET);
    end else begin
      ptr_q <= ptr_d;
      mod_q <= mod_d;
    end
  end

  assign ptr_o     = ptr_q;
  assign ptr_nxt_o = ptr_d;

endmodule

// File: rtl/vram_fast_ctrl.sv
// Sequencer for the fast VRAM pair: arbitrates video fetch over host access
// and drives fully registered strobes, address and write data onto the SRAMs.
module vram_fast_ctrl #(
  parameter int ADDR_W = vram_fast_pkg::ADDR_W,
  parameter int DATA_W = vram_fast_pkg::DATA_W
) (
  input  logic              CLK_24M,
  input  logic              RESET,
  vram_fast_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DATA,
  output logic              nCE,
  output logic              nOE,
  output logic              nWE
);
  import vram_fast_pkg::*;

  state_e            state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drv_q;
  logic              nce_q, noe_q, nwe_q;
  logic              ack_q, vld_q;
  logic [DATA_W-1:0] rdata_q, fdata_q;
  logic [ADDR_W-1:0] ptr_nxt;

  // Increment fires while ACK is high, so it lands on the edge ending the pulse.
  vram_fast_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .clk_i     (CLK_24M),
    .rst_i     (RESET),
    .ptr_ld_i  (bus.PTR_LD),
    .ptr_in_i  (bus.PTR_IN),
    .mod_ld_i  (bus.MOD_LD),
    .mod_in_i  (bus.MOD_IN),
    .inc_i     (ack_q),
    .ptr_o     (bus.PTR),
    .ptr_nxt_o (ptr_nxt)
  );

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state_q <= IDLE;
      owner_q <= OWN_HOST;
      addr_q  <= '0;
      drv_q   <= 1'b0;
      nce_q   <= 1'b1;
      noe_q   <= 1'b1;
      nwe_q   <= 1'b1;
      ack_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      fdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      vld_q <= 1'b0;
      case (state_q)
        // IDLE also closes out a write: nCE and the data bus stay active
        // through the cycle after WR_HOLD to give the write its hold time.
        IDLE: begin
          nce_q <= 1'b1;
          noe_q <= 1'b1;
          nwe_q <= 1'b1;
          drv_q <= 1'b0;
          if (bus.FETCH_REQ) begin
            owner_q <= OWN_FETCH;
            addr_q  <= bus.FETCH_ADDR;
            state_q <= RD_SETUP;
          end else if (bus.HOST_REQ) begin
            // ptr_nxt covers an increment landing on this same edge.
            owner_q <= OWN_HOST;
            addr_q  <= ptr_nxt;
            wdata_q <= bus.HOST_WDATA;
            state_q <= bus.HOST_WR ? WR_SETUP : RD_SETUP;
          end
        end
        RD_SETUP: begin
          nce_q   <= 1'b0;
          noe_q   <= 1'b0;
          state_q <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          if (owner_q == OWN_FETCH) begin
            fdata_q <= DATA;
            vld_q   <= 1'b1;
          end else begin
            rdata_q <= DATA;
            ack_q   <= 1'b1;
          end
          nce_q   <= 1'b1;
          noe_q   <= 1'b1;
          state_q <= IDLE;
        end
        WR_SETUP: begin
          nce_q   <= 1'b0;
          nwe_q   <= 1'b1;
          drv_q   <= 1'b1;
          state_q <= WR_PULSE;
        end
        WR_PULSE: begin
          nwe_q   <= 1'b0;
          state_q <= WR_HOLD;
        end
        WR_HOLD: begin
          nwe_q   <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ADDR            = addr_q;
  assign DATA            = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign nCE             = nce_q;
  assign nOE             = noe_q;
  assign nWE             = nwe_q;
  assign bus.HOST_ACK    = ack_q;
  assign bus.HOST_RDATA  = rdata_q;
  assign bus.FETCH_VALID = vld_q;
  assign bus.FETCH_DATA  = fdata_q;

endmodule

// File: tb/tb_vram_fast_ctrl.sv
// Directed bench for vram_fast_ctrl with a behavioural L/U SRAM pair on DATA
// and a free-running strobe/pulse protocol monitor.
module tb_vram_fast_ctrl;

  logic        clk;
  logic        RESET;
  wire  [15:0] DATA;
  logic [10:0] ADDR;
  logic        nCE, nOE, nWE;

  vram_fast_ctrl_if bus ();

  vram_fast_ctrl dut (
    .CLK_24M (clk),
    .RESET   (RESET),
    .bus     (bus),
    .ADDR    (ADDR),
    .DATA    (DATA),
    .nCE     (nCE),
    .nOE     (nOE),
    .nWE     (nWE)
  );

  // Fast VRAM halves: L on DATA[7:0], U on DATA[15:8]; write at rising nWE.
  logic [7:0] mem_l [0:2047];
  logic [7:0] mem_u [0:2047];

  assign DATA = (!nCE && !nOE) ? {mem_u[ADDR], mem_l[ADDR]} : 16'bz;

  always @(posedge nWE) begin
    if (!nCE) begin
      mem_l[ADDR] <= DATA[7:0];
      mem_u[ADDR] <= DATA[15:8];
    end
  end

  function automatic logic [15:0] sram(input logic [10:0] a);
    return {mem_u[a], mem_l[a]};
  endfunction

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  logic        mon_en = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_vld = 1'b0;
  logic [15:0] exp_wd = 16'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("oe_we_excl", {31'b0, (nOE | nWE)}, 32'd1);
      if (bus.HOST_ACK)    chk("ack_pulse", {31'b0, prev_ack}, 32'd0);
      if (bus.FETCH_VALID) chk("vld_pulse", {31'b0, prev_vld}, 32'd0);
      if (!nWE)            chk("wr_bus_data", {16'b0, DATA}, {16'b0, exp_wd});
      if (bus.HOST_ACK && !prev_ack) ack_cnt <= ack_cnt + 1;
    end
    prev_ack <= bus.HOST_ACK;
    prev_vld <= bus.FETCH_VALID;
  end

  task automatic load(input logic ldp, input logic [10:0] p, input logic ldm, input logic [10:0] m);
    @(negedge clk);
    bus.PTR_LD = ldp; bus.PTR_IN = p;
    bus.MOD_LD = ldm; bus.MOD_IN = m;
    @(negedge clk);
    bus.PTR_LD = 1'b0;
    bus.MOD_LD = 1'b0;
  endtask

  // Returns ACK latency counted from the edge that sampled the request.
  task automatic host_op(input logic wr, input logic [15:0] wd, input logic ld,
                         input logic [10:0] ldv, output int lat);
    int c0;
    lat = -1;
    @(negedge clk);
    bus.HOST_WR = wr; bus.HOST_WDATA = wd; exp_wd = wd;
    bus.HOST_REQ = 1'b1;
    c0 = cyc + 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.HOST_ACK) begin
        lat = cyc - c0;
        break;
      end
    end
    bus.HOST_REQ = 1'b0;
    if (ld) begin
      bus.PTR_LD = 1'b1;
      bus.PTR_IN = ldv;
    end
    @(negedge clk);
    bus.PTR_LD = 1'b0;
  endtask

  initial begin
    int lat, fl, hl, c0, acks;
    logic [15:0] fdat;
    RESET = 1'b1;
    bus.HOST_REQ = 1'b0; bus.HOST_WR = 1'b0; bus.HOST_WDATA = 16'h0;
    bus.PTR_LD = 1'b0; bus.PTR_IN = 11'h0; bus.MOD_LD = 1'b0; bus.MOD_IN = 11'h0;
    bus.FETCH_REQ = 1'b0; bus.FETCH_ADDR = 11'h0;

    repeat (3) @(negedge clk);
    chk("rst_nCE", {31'b0, nCE}, 32'd1);
    chk("rst_nOE", {31'b0, nOE}, 32'd1);
    chk("rst_nWE", {31'b0, nWE}, 32'd1);
    chk("rst_ADDR", {21'b0, ADDR}, 32'h0);
    chk("rst_ACK", {31'b0, bus.HOST_ACK}, 32'd0);
    chk("rst_VALID", {31'b0, bus.FETCH_VALID}, 32'd0);
    chk("rst_RDATA", {16'b0, bus.HOST_RDATA}, 32'h0);
    chk("rst_FDATA", {16'b0, bus.FETCH_DATA}, 32'h0);
    chk("rst_PTR", {21'b0, bus.PTR}, 32'h0);
    RESET = 1'b0;
    mon_en = 1'b1;

    // Modulo 3 from 0x7FE: second write wraps to 0x001.
    load(1'b1, 11'h7FE, 1'b1, 11'd3);
    chk("ptr_load", {21'b0, bus.PTR}, 32'h7FE);
    host_op(1'b1, 16'hA5A5, 1'b0, 11'h0, lat);
    chk("wr1_lat", lat, 32'd3);
    chk("wr1_ptr", {21'b0, bus.PTR}, 32'h001);
    host_op(1'b1, 16'h5A5A, 1'b0, 11'h0, lat);
    chk("wr2_lat", lat, 32'd3);
    chk("wr2_ptr", {21'b0, bus.PTR}, 32'h004);
    chk("mem_7fe", {16'b0, sram(11'h7FE)}, 32'hA5A5);
    chk("mem_001", {16'b0, sram(11'h001)}, 32'h5A5A);

    // Host read at 0x010 with modulo 1.
    load(1'b1, 11'h010, 1'b1, 11'd1);
    host_op(1'b1, 16'h1234, 1'b0, 11'h0, lat);
    load(1'b1, 11'h010, 1'b0, 11'h0);
    host_op(1'b0, 16'h0, 1'b0, 11'h0, lat);
    chk("rd_lat", lat, 32'd2);
    chk("rd_data", {16'b0, bus.HOST_RDATA}, 32'h1234);
    chk("rd_ptr", {21'b0, bus.PTR}, 32'h011);

    // Fetch and host in the same cycle: fetch first.
    host_op(1'b1, 16'hBEEF, 1'b0, 11'h0, lat);
    load(1'b1, 11'h010, 1'b0, 11'h0);
    @(negedge clk);
    bus.FETCH_ADDR = 11'h011; bus.FETCH_REQ = 1'b1;
    bus.HOST_WR = 1'b0; bus.HOST_REQ = 1'b1;
    c0 = cyc + 1; fl = -1; hl = -1; fdat = 16'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.FETCH_VALID && fl < 0) begin
        fl = cyc - c0; fdat = bus.FETCH_DATA; bus.FETCH_REQ = 1'b0;
      end
      if (bus.HOST_ACK && hl < 0) begin
        hl = cyc - c0; bus.HOST_REQ = 1'b0;
      end
    end
    bus.FETCH_REQ = 1'b0; bus.HOST_REQ = 1'b0;
    chk("arb_fetch_lat", fl, 32'd2);
    chk("arb_fetch_data", {16'b0, fdat}, 32'hBEEF);
    chk("arb_host_lat", hl, 32'd5);
    chk("arb_host_data", {16'b0, bus.HOST_RDATA}, 32'h1234);
    chk("arb_ptr", {21'b0, bus.PTR}, 32'h011);

    // Pointer load coinciding with ACK beats the increment.
    host_op(1'b1, 16'h7777, 1'b1, 11'h100, lat);
    chk("ldack_lat", lat, 32'd3);
    chk("ldack_ptr", {21'b0, bus.PTR}, 32'h100);
    chk("mem_011", {16'b0, sram(11'h011)}, 32'h7777);

    // Reset while in WR_PULSE aborts the write.
    @(negedge clk);
    bus.HOST_WR = 1'b1; bus.HOST_WDATA = 16'h5555; exp_wd = 16'h5555;
    bus.HOST_REQ = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_nCE", {31'b0, nCE}, 32'd0);
    RESET = 1'b1;
    acks = ack_cnt;
    @(negedge clk);
    bus.HOST_REQ = 1'b0;
    chk("abort_nCE", {31'b0, nCE}, 32'd1);
    chk("abort_nWE", {31'b0, nWE}, 32'd1);
    chk("abort_nOE", {31'b0, nOE}, 32'd1);
    chk("abort_ACK", {31'b0, bus.HOST_ACK}, 32'd0);
    chk("abort_PTR", {21'b0, bus.PTR}, 32'h0);
    RESET = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_ack", ack_cnt, acks);

    // After reset: bus released, modulo back to 1.
    load(1'b1, 11'h7FE, 1'b0, 11'h0);
    host_op(1'b0, 16'h0, 1'b0, 11'h0, lat);
    chk("post_rd_lat", lat, 32'd2);
    chk("post_rd_data", {16'b0, bus.HOST_RDATA}, 32'hA5A5);
    chk("post_rd_ptr", {21'b0, bus.PTR}, 32'h7FF);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
